// File: rtl/bdm_pkg.sv
// Shared types, default per-bit timing constants and helpers for the BDM byte engine.
package bdm_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StBit  = 2'd2,
    StDone = 2'd3
  } bdm_state_e;

  typedef enum logic {
    ModeRx = 1'b0,
    ModeTx = 1'b1
  } bdm_mode_e;

  // Per-bit timing in target clock cycles.
  localparam int unsigned DefLow1Tc   = 4;
  localparam int unsigned DefLow0Tc   = 13;
  localparam int unsigned DefSampleTc = 10;
  localparam int unsigned DefBitTc    = 16;

  // sync_length counts host clocks per 128 target clocks.
  localparam int unsigned TcShift = 7;
  localparam int unsigned TcWidth = 32 - TcShift;

  // Multiply by a constant as a shift/add chain; k is always elaboration-time constant.
  function automatic logic [31:0] mul_const(input logic [31:0] x, input int unsigned k);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < 32; i++) begin
      if (k[i]) acc = acc + (x << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/bdm_byte_engine_if.sv
// Host-side bus of the BDM byte engine: timing input, start requests, line and status.
interface bdm_byte_engine_if;

  logic [31:0] sync_length;
  logic        sync_length_is_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        rx_start;
  logic        bkgd_in;
  logic        bkgd_oe;
  logic        busy;
  logic        done;
  logic [7:0]  rx_data;
  logic        start_rejected;

  // Host / line side that requests transfers.
  modport master (
    output sync_length,
    output sync_length_is_ready,
    output tx_start,
    output tx_data,
    output rx_start,
    output bkgd_in,
    input  bkgd_oe,
    input  busy,
    input  done,
    input  rx_data,
    input  start_rejected
  );

  // Engine side.
  modport slave (
    input  sync_length,
    input  sync_length_is_ready,
    input  tx_start,
    input  tx_data,
    input  rx_start,
    input  bkgd_in,
    output bkgd_oe,
    output busy,
    output done,
    output rx_data,
    output start_rejected
  );

endinterface

// File: rtl/bdm_timing_calc.sv
// Converts the latched target-clock period (tc) into host-clock bit timings.
// Results are registered on load_i and held for the whole transfer.
module bdm_timing_calc
  import bdm_pkg::*;
#(
  parameter int unsigned LOW1_TC   = DefLow1Tc,
  parameter int unsigned LOW0_TC   = DefLow0Tc,
  parameter int unsigned SAMPLE_TC = DefSampleTc,
  parameter int unsigned BIT_TC    = DefBitTc
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [TcWidth-1:0] tc_i,
  output logic [31:0]        l1_o,
  output logic [31:0]        l0_o,
  output logic [31:0]        smp_o,
  output logic [31:0]        bt_o
);

  logic [31:0] tc_clamped;
  logic [31:0] l1_d, l1_q;
  logic [31:0] l0_d, l0_q;
  logic [31:0] smp_d, smp_q;
  logic [31:0] bt_d, bt_q;

  // Clamp tc to at least one host clock and scale it by each per-bit constant.
  always_comb begin
    tc_clamped = {{TcShift{1'b0}}, tc_i};
    if (tc_i == '0) tc_clamped = 32'd1;
    l1_d  = l1_q;
    l0_d  = l0_q;
    smp_d = smp_q;
    bt_d  = bt_q;
    if (load_i) begin
      l1_d  = mul_const(tc_clamped, LOW1_TC);
      l0_d  = mul_const(tc_clamped, LOW0_TC);
      smp_d = mul_const(tc_clamped, SAMPLE_TC);
      bt_d  = mul_const(tc_clamped, BIT_TC);
    end
  end

  // Timing registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      l1_q  <= '0;
      l0_q  <= '0;
      smp_q <= '0;
      bt_q  <= '0;
    end else begin
      l1_q  <= l1_d;
      l0_q  <= l0_d;
      smp_q <= smp_d;
      bt_q  <= bt_d;
    end
  end

  assign l1_o  = l1_q;
  assign l0_o  = l0_q;
  assign smp_o = smp_q;
  assign bt_o  = bt_q;

endmodule

// File: rtl/bdm_byte_engine.sv
// BDM byte engine: sends or receives one byte MSB first on the open-drain BKGD line,
// with bit timing derived from the measured sync length.
module bdm_byte_engine
  import bdm_pkg::*;
#(
  parameter int unsigned LOW1_TC   = DefLow1Tc,
  parameter int unsigned LOW0_TC   = DefLow0Tc,
  parameter int unsigned SAMPLE_TC = DefSampleTc,
  parameter int unsigned BIT_TC    = DefBitTc
) (
  input logic              clk,
  input logic              rst,
  bdm_byte_engine_if.slave bus
);

  bdm_state_e         state_d, state_q;
  bdm_mode_e          mode_d, mode_q;
  logic [7:0]         shift_d, shift_q;
  logic [TcWidth-1:0] tc_d, tc_q;
  logic [2:0]         bit_idx_d, bit_idx_q;
  logic [31:0]        cnt_d, cnt_q;
  logic               bkgd_oe_d, bkgd_oe_q;
  logic               busy_d, busy_q;
  logic               done_d, done_q;
  logic [7:0]         rx_data_d, rx_data_q;
  logic               start_rejected_d, start_rejected_q;

  logic        start;
  logic        timing_load;
  logic [31:0] l1, l0, smp, bt;
  logic [31:0] low_len;
  logic        bit_end;
  logic        last_bit;

  // Fractional target-clock bits of sync_length are below one host clock per target clock.
  logic unused_sync_lsbs;
  assign unused_sync_lsbs = ^bus.sync_length[TcShift-1:0];

  assign start       = bus.tx_start | bus.rx_start;
  assign timing_load = (state_q == StLoad);
  assign bit_end     = (cnt_q == bt - 32'd1);
  assign last_bit    = (bit_idx_q == 3'd7);
  assign low_len     = ((mode_q == ModeTx) && !shift_q[7]) ? l0 : l1;

  bdm_timing_calc #(
    .LOW1_TC  (LOW1_TC),
    .LOW0_TC  (LOW0_TC),
    .SAMPLE_TC(SAMPLE_TC),
    .BIT_TC   (BIT_TC)
  ) u_timing (
    .clk   (clk),
    .rst   (rst),
    .load_i(timing_load),
    .tc_i  (tc_q),
    .l1_o  (l1),
    .l0_o  (l0),
    .smp_o (smp),
    .bt_o  (bt)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= StIdle;
      mode_q           <= ModeRx;
      shift_q          <= '0;
      tc_q             <= '0;
      bit_idx_q        <= '0;
      cnt_q            <= '0;
      bkgd_oe_q        <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      rx_data_q        <= '0;
      start_rejected_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      mode_q           <= mode_d;
      shift_q          <= shift_d;
      tc_q             <= tc_d;
      bit_idx_q        <= bit_idx_d;
      cnt_q            <= cnt_d;
      bkgd_oe_q        <= bkgd_oe_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      rx_data_q        <= rx_data_d;
      start_rejected_q <= start_rejected_d;
    end
  end

  // Next-state: accept a start only with valid timing, run eight bit frames, then finish.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start && bus.sync_length_is_ready) state_d = StLoad;
      StLoad:  state_d = StBit;
      StBit:   if (bit_end && last_bit) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath and registered outputs for each state.
  always_comb begin
    mode_d           = mode_q;
    shift_d          = shift_q;
    tc_d             = tc_q;
    bit_idx_d        = bit_idx_q;
    cnt_d            = cnt_q;
    bkgd_oe_d        = 1'b0;
    busy_d           = busy_q;
    done_d           = 1'b0;
    rx_data_d        = rx_data_q;
    start_rejected_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (!bus.sync_length_is_ready) begin
            start_rejected_d = 1'b1;
          end else begin
            busy_d  = 1'b1;
            // tx wins over a simultaneous rx request.
            mode_d  = bus.tx_start ? ModeTx : ModeRx;
            shift_d = bus.tx_start ? bus.tx_data : 8'h00;
            tc_d    = bus.sync_length[31:TcShift];
          end
        end
      end
      StLoad: begin
        bit_idx_d = '0;
        cnt_d     = '0;
      end
      StBit: begin
        bkgd_oe_d = (cnt_q < low_len);
        if ((mode_q == ModeRx) && (cnt_q == smp)) begin
          shift_d = {shift_q[6:0], bus.bkgd_in};
        end
        if (bit_end) begin
          cnt_d = '0;
          if (mode_q == ModeTx) shift_d = {shift_q[6:0], 1'b0};
          if (!last_bit) bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StDone: begin
        done_d = 1'b1;
        busy_d = 1'b0;
        if (mode_q == ModeRx) rx_data_d = shift_q;
      end
      default: ;
    endcase
  end

  assign bus.bkgd_oe        = bkgd_oe_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.rx_data        = rx_data_q;
  assign bus.start_rejected = start_rejected_q;

endmodule

// File: tb/tb_bdm_byte_engine.sv
// Self-checking bench for bdm_byte_engine: directed scenarios plus randomized transfers
// checked against a frame-level reference of the BKGD protocol.
module tb_bdm_byte_engine;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bdm_byte_engine_if bus ();

  bdm_byte_engine dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  logic [7:0] exp_rx = 8'h00;

  // Edge counter: value seen at a negedge is the index of the preceding posedge.
  always @(posedge clk) cyc <= cyc + 1;

  // Line monitor: low-pulse start/length, done pulses, reject pulses, oe outside a transfer.
  int   pulse_len[$];
  int   pulse_rise[$];
  int   done_at[$];
  int   rej_cnt = 0;
  int   oe_no_busy = 0;
  int   rise_t = 0;
  logic oe_prev = 1'b0;
  always @(negedge clk) begin
    if (bus.bkgd_oe === 1'b1 && oe_prev === 1'b0) rise_t = cyc;
    if (bus.bkgd_oe === 1'b0 && oe_prev === 1'b1) begin
      pulse_rise.push_back(rise_t);
      pulse_len.push_back(cyc - rise_t);
    end
    if (bus.done === 1'b1) done_at.push_back(cyc);
    if (bus.start_rejected === 1'b1) rej_cnt++;
    if (bus.bkgd_oe === 1'b1 && bus.busy !== 1'b1) oe_no_busy++;
    oe_prev = bus.bkgd_oe;
  end

  // Target model: on each host low pulse, holds the line low for tgt_hold clocks on a 0-bit.
  logic [7:0] tgt_byte = 8'h00;
  bit         tgt_en = 1'b0;
  int         tgt_hold = 0;
  int         tgt_idx = 0;
  int         tgt_left = 0;
  logic       tgt_low = 1'b0;
  logic       tgt_oe_prev = 1'b0;
  always @(negedge clk) begin
    if (tgt_en && bus.bkgd_oe === 1'b1 && tgt_oe_prev !== 1'b1) begin
      tgt_low  = (tgt_idx < 8) ? !tgt_byte[7 - tgt_idx] : 1'b0;
      tgt_left = tgt_hold;
      tgt_idx++;
    end else if (tgt_left > 0) begin
      tgt_left--;
      if (tgt_left == 0) tgt_low = 1'b0;
    end
    tgt_oe_prev = bus.bkgd_oe;
  end
  assign bus.bkgd_in = ~(bus.bkgd_oe | tgt_low);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transfer; expectations come from frame rules: 16*tc per bit, low 4*tc or 13*tc.
  task automatic xfer(input bit do_tx, input bit do_rx, input logic [7:0] data,
                      input logic [7:0] tgt, input logic [31:0] sl, input bit inject,
                      input string tag);
    int tc, bt, n, t, exp_len;
    tc = int'(sl >> 7);
    if (tc == 0) tc = 1;
    bt = 16 * tc;
    pulse_len.delete();
    pulse_rise.delete();
    done_at.delete();
    rej_cnt  = 0;
    tgt_byte = tgt;
    tgt_idx  = 0;
    tgt_hold = 14 * tc;
    tgt_en   = !do_tx;
    @(negedge clk);
    bus.sync_length          = sl;
    bus.sync_length_is_ready = 1'b1;
    bus.tx_data              = data;
    bus.tx_start             = do_tx;
    bus.rx_start             = do_rx;
    n = cyc + 1;
    @(negedge clk);
    bus.tx_start    = 1'b0;
    bus.rx_start    = 1'b0;
    bus.tx_data     = ~data;
    bus.sync_length = $urandom;
    chk({tag, " busy_after_start"}, 32'(bus.busy), 32'd1);
    t = 0;
    while (done_at.size() == 0 && t < 8 * bt + 40) begin
      @(negedge clk);
      t++;
      if (inject && t == bt / 2) begin
        bus.tx_start = 1'b1;
        bus.rx_start = 1'b1;
      end else if (inject && t == bt / 2 + 1) begin
        bus.tx_start = 1'b0;
        bus.rx_start = 1'b0;
      end
    end
    repeat (3) @(negedge clk);
    chk({tag, " done_count"}, 32'(done_at.size()), 32'd1);
    if (done_at.size() > 0) chk({tag, " done_time"}, 32'(done_at[0]), 32'(n + 2 + 8 * bt));
    chk({tag, " pulse_count"}, 32'(pulse_len.size()), 32'd8);
    for (int i = 0; i < 8 && i < pulse_len.size(); i++) begin
      exp_len = (do_tx && !data[7 - i]) ? 13 * tc : 4 * tc;
      chk($sformatf("%s bit%0d_low_len", tag, i), 32'(pulse_len[i]), 32'(exp_len));
      chk($sformatf("%s bit%0d_rise", tag, i), 32'(pulse_rise[i]), 32'(n + 2 + i * bt));
    end
    if (!do_tx) exp_rx = tgt;
    chk({tag, " rx_data"}, 32'(bus.rx_data), 32'(exp_rx));
    chk({tag, " busy_after_done"}, 32'(bus.busy), 32'd0);
    chk({tag, " no_reject"}, 32'(rej_cnt), 32'd0);
    tgt_en = 1'b0;
  endtask

  initial begin
    int n, t;
    logic [31:0] sl;
    logic [7:0]  d, g;
    bit          is_tx;

    rst                      = 1'b1;
    bus.sync_length          = '0;
    bus.sync_length_is_ready = 1'b0;
    bus.tx_start             = 1'b0;
    bus.tx_data              = '0;
    bus.rx_start             = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset bkgd_oe", 32'(bus.bkgd_oe), 32'd0);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset rx_data", 32'(bus.rx_data), 32'd0);
    chk("reset start_rejected", 32'(bus.start_rejected), 32'd0);

    xfer(1'b1, 1'b0, 8'hA5, 8'h00, 32'd1280, 1'b0, "tx_a5");
    xfer(1'b0, 1'b1, 8'h00, 8'h3C, 32'd1280, 1'b0, "rx_3c");
    xfer(1'b1, 1'b0, 8'hFF, 8'h00, 32'd100, 1'b0, "tx_ff_tc1");

    // Start without valid timing is refused.
    @(negedge clk);
    rej_cnt                  = 0;
    bus.sync_length_is_ready = 1'b0;
    bus.tx_start             = 1'b1;
    @(negedge clk);
    bus.tx_start = 1'b0;
    chk("reject pulse", 32'(bus.start_rejected), 32'd1);
    chk("reject busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("reject pulse_end", 32'(bus.start_rejected), 32'd0);
    repeat (5) @(negedge clk);
    chk("reject busy_later", 32'(bus.busy), 32'd0);
    chk("reject oe", 32'(bus.bkgd_oe), 32'd0);
    chk("reject count", 32'(rej_cnt), 32'd1);
    bus.sync_length_is_ready = 1'b1;

    // Simultaneous tx+rx: tx wins; a start while busy is ignored.
    xfer(1'b1, 1'b1, 8'h3C, 8'h00, 32'd256, 1'b1, "both_inject");

    // Reset in the middle of bit 3 (a 0-bit, so the line is being driven).
    @(negedge clk);
    done_at.delete();
    bus.sync_length = 32'd1280;
    bus.tx_data     = 8'h80;
    bus.tx_start    = 1'b1;
    n = cyc + 1;
    @(negedge clk);
    bus.tx_start = 1'b0;
    t = 0;
    while (cyc < n + 2 + 3 * 160 + 70 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("rst pre_oe", 32'(bus.bkgd_oe), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst oe", 32'(bus.bkgd_oe), 32'd0);
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst rx_data", 32'(bus.rx_data), 32'd0);
    rst    = 1'b0;
    exp_rx = 8'h00;
    repeat (5 * 160) @(negedge clk);
    chk("rst no_done", 32'(done_at.size()), 32'd0);
    xfer(1'b1, 1'b0, 8'h5A, 8'h00, 32'd1280, 1'b0, "after_rst");

    // Randomized transfers.
    for (int k = 0; k < 8; k++) begin
      sl    = 32'($urandom_range(0, 1023));
      is_tx = 1'($urandom_range(0, 1));
      d     = 8'($urandom);
      g     = 8'($urandom);
      xfer(is_tx, !is_tx, d, g, sl, 1'($urandom_range(0, 1)), $sformatf("rand%0d", k));
    end

    chk("oe_only_while_busy", 32'(oe_no_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
